uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. Supports configurable data width, optional even/odd parity and 1 or 2 stop bits. Reports each frame with a one-cycle valid strobe and framing/parity error flags. Sits between the async serial pin and the byte-level consumer (FIFO or register bank) in the rx_clk domain.

Parameters:
CLKS_PER_BIT, 521, rx_clk cycles per bit (rx_clk freq / baud); legal >= 4.
DATA_BITS, 8, data bits per frame; legal 5..9; sent LSB first.
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
STOP_BITS, 1, stop bits per frame; legal 1 or 2.

Ports:
rx_clk  input  1  single clock; every flop is on its rising edge.
rx_rst_n  input  1  synchronous, active-low reset.
rx_in  input  1  asynchronous serial line; idles high.
rx_out  output  DATA_BITS  last received data word; holds until the next frame completes.
rx_valid  output  1  one-cycle strobe: rx_out and the error flags are valid.
rx_frame_err  output  1  a stop bit sampled 0; qualified by rx_valid.
rx_parity_err  output  1  parity mismatch; qualified by rx_valid; always 0 when PARITY_EN = 0.
rx_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset is synchronous and active-low (rx_rst_n sampled on rx_clk). It forces state IDLE, both synchronizer flops to 1, all counters to 0, rx_out = 0 and rx_valid/rx_frame_err/rx_parity_err/rx_busy = 0.
- Reset mid-frame abandons the frame with no strobe.
- rx_in passes through a 2-flop synchronizer; the sampled value "s" is the second flop (2-cycle latency).
- Bit counter width is $clog2(CLKS_PER_BIT); bit index width is $clog2(DATA_BITS + 1).
- FSM states:
  - IDLE: counter = 0. When s = 0, go to START.
  - START: count to (CLKS_PER_BIT-1)/2 (integer divide). At that count, if s = 0, clear the counter and go to DATA. If s = 1, treat it as a glitch: return to IDLE with no strobe and no error.
  - DATA: at count CLKS_PER_BIT-1, shift s into the MSB of the shift register (right shift, LSB-first line order), clear the counter and increment the bit index. After DATA_BITS samples, go to PARITY if PARITY_EN = 1, else go to STOP.
  - PARITY: sample after one full bit time. Error when (XOR of data bits XOR parity bit) differs from PARITY_ODD.
  - STOP: sample each stop bit after one full bit time. Any stop sample = 0 sets the frame error.
- Completion: on the edge that samples the last stop bit, load rx_out from the shift register and register both error flags. rx_valid = 1 for exactly the next cycle. The FSM returns to IDLE at mid-stop-bit, so a back-to-back start edge is caught.
- Latency: rx_valid rises about 2 + (CLKS_PER_BIT-1)/2 + (DATA_BITS + PARITY_EN + STOP_BITS)*CLKS_PER_BIT cycles after the rx_in falling edge.
- Error reporting: data is delivered even on a framing or parity error. Error flags update only with rx_valid and are 0 on every other cycle.
- A line held low (break) yields a frame with data 0 and rx_frame_err = 1. The receiver then stays in IDLE until the line returns high.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: a 3-deep history of synchronized samples is kept. Every sample point (start, data, parity, stop) uses the 2-of-3 majority of the current and two previous s values. Added latency: none.
- Undefined: the single sample s is used, and the history flops are not instantiated.

Decomposition:
- Package uart_pkg holds:
  - the state enum: IDLE, START, DATA, PARITY, STOP (3-bit);
  - parity-mode constants PAR_EVEN = 0 and PAR_ODD = 1;
  - a function for the counter-width clog2.
- Sub-module uart_rx_sync contains the 2-flop synchronizer plus the optional majority filter, and outputs the sample bit.
- The FSM, counters and shift register stay in uart_rx_param.

Test Plan:
- Defaults changed to CLKS_PER_BIT = 16, 8N1; send 0xA5 -> one rx_valid pulse, rx_out = 0xA5, both error flags = 0.
- PARITY_EN = 1, PARITY_ODD = 0; send 0x07 with parity bit 1 -> rx_parity_err = 0. Resend with parity bit 0 -> rx_out = 0x07, rx_parity_err = 1.
- STOP_BITS = 2; send 0x3C with the second stop bit 0 -> rx_out = 0x3C, rx_frame_err = 1, exactly one rx_valid pulse.
- 3-cycle low glitch on idle rx_in -> FSM returns to IDLE, no rx_valid, rx_busy deasserts within 8 cycles.
- DATA_BITS = 5; two frames 0x15 then 0x0A back-to-back with no idle gap -> two rx_valid pulses, outputs 0x15 then 0x0A.
- Drive rx_rst_n = 0 for 1 cycle during bit 4 of a frame -> no rx_valid, rx_out = 0; the next clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types, constants and helper functions for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Width of the per-bit cycle counter; never narrower than one bit.
  function automatic int cnt_width(input int clks);
    if (clks <= 32'sd2) begin
      return 32'sd1;
    end else begin
      return $clog2(clks);
    end
  endfunction

  // XOR reduction over a data word zero-extended to the widest legal frame.
  function automatic logic parity9(input logic [8:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line, with an optional 2-of-3 majority
// filter over the synchronized samples (enabled by UART_RX_MAJORITY_EN).
module uart_rx_sync (
  input  logic rx_clk,
  input  logic rx_rst_n,
  input  logic rx_in,
  output logic sample
);

  logic sync1_r;
  logic sync2_r;

  // Metastability chain; resets to the idle (high) line level.
  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx_in;
      sync2_r <= sync1_r;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic hist1_r;
  logic hist2_r;

  // History of the two previous synchronized samples.
  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      hist1_r <= 1'b1;
      hist2_r <= 1'b1;
    end else begin
      hist1_r <= sync2_r;
      hist2_r <= hist1_r;
    end
  end

  assign sample = (sync2_r & hist1_r) | (sync2_r & hist2_r) | (hist1_r & hist2_r);
`else
  assign sample = sync2_r;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, parity and stop bits.
// Optional majority sampling is selected with the UART_RX_MAJORITY_EN macro.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 521,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_out,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_busy
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_CNT  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FULL_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  localparam logic PAR_MODE = (PARITY_ODD != 32'sd0) ? PAR_ODD : PAR_EVEN;
  localparam uart_state_e AFTER_DATA = (PARITY_EN != 32'sd0) ? PARITY : STOP;

  logic                 sample_s;
  uart_state_e          state_r, state_n;
  logic [CW-1:0]        cnt_r, cnt_n;
  logic [IW-1:0]        idx_r, idx_n;
  logic [DATA_BITS-1:0] shift_r, shift_n;
  logic                 ferr_r, ferr_n;
  logic                 perr_r, perr_n;
  logic                 brk_r, brk_n;
  logic                 done_s;

  uart_rx_sync u_sync (
    .rx_clk   (rx_clk),
    .rx_rst_n (rx_rst_n),
    .rx_in    (rx_in),
    .sample   (sample_s)
  );

  // Next-state, counters, shift register and error accumulation.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    idx_n   = idx_r;
    shift_n = shift_r;
    ferr_n  = ferr_r;
    perr_n  = perr_r;
    brk_n   = brk_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_n  = '0;
        idx_n  = '0;
        ferr_n = 1'b0;
        perr_n = 1'b0;
        // After a low stop sample the line must return high before a new start.
        if (brk_r) begin
          brk_n = ~sample_s;
        end else if (!sample_s) begin
          state_n = START;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_CNT) begin
          cnt_n   = '0;
          state_n = sample_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt_r + CW'(1);
        end
      end
      DATA: begin
        if (cnt_r == FULL_CNT) begin
          cnt_n   = '0;
          shift_n = {sample_s, shift_r[DATA_BITS-1:1]};
          if (idx_r == LAST_DATA) begin
            idx_n   = '0;
            state_n = AFTER_DATA;
          end else begin
            idx_n = idx_r + IW'(1);
          end
        end else begin
          cnt_n = cnt_r + CW'(1);
        end
      end
      PARITY: begin
        if (cnt_r == FULL_CNT) begin
          cnt_n   = '0;
          perr_n  = (parity9(9'(shift_r)) ^ sample_s) != PAR_MODE;
          state_n = STOP;
        end else begin
          cnt_n = cnt_r + CW'(1);
        end
      end
      STOP: begin
        if (cnt_r == FULL_CNT) begin
          cnt_n  = '0;
          ferr_n = ferr_r | ~sample_s;
          if (idx_r == LAST_STOP) begin
            idx_n   = '0;
            done_s  = 1'b1;
            brk_n   = ~sample_s;
            state_n = IDLE;
          end else begin
            idx_n = idx_r + IW'(1);
          end
        end else begin
          cnt_n = cnt_r + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

  // FSM, counters and datapath registers.
  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
      shift_r <= '0;
      ferr_r  <= 1'b0;
      perr_r  <= 1'b0;
      brk_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      idx_r   <= idx_n;
      shift_r <= shift_n;
      ferr_r  <= ferr_n;
      perr_r  <= perr_n;
      brk_r   <= brk_n;
    end
  end

  // Registered frame report; error flags are only ever high alongside rx_valid.
  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      rx_out        <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_valid <= done_s;
      rx_busy  <= (state_n != IDLE);
      if (done_s) begin
        rx_out        <= shift_r;
        rx_frame_err  <= ferr_n;
        rx_parity_err <= (PARITY_EN != 32'sd0) ? perr_r : 1'b0;
      end else begin
        rx_frame_err  <= 1'b0;
        rx_parity_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: four instances (8N1, 8E1, 8N2, 5N1) at 16 clocks/bit.
module tb_uart_rx_param;

  localparam int CPB = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       rx_clk = 1'b0;
  logic       rx_rst_n = 1'b0;
  logic       rx_line [4];
  logic [8:0] out_w   [4];
  logic       val_w   [4];
  logic       fe_w    [4];
  logic       pe_w    [4];
  logic       busy_w  [4];
  logic [7:0] out_a, out_b, out_c;
  logic [4:0] out_d;

  exp_t q0[$], q1[$], q2[$], q3[$];
  int total = 0;
  int bad = 0;

  always #5 rx_clk = ~rx_clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB)) u_a (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_in(rx_line[0]), .rx_out(out_a),
    .rx_valid(val_w[0]), .rx_frame_err(fe_w[0]), .rx_parity_err(pe_w[0]), .rx_busy(busy_w[0]));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u_b (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_in(rx_line[1]), .rx_out(out_b),
    .rx_valid(val_w[1]), .rx_frame_err(fe_w[1]), .rx_parity_err(pe_w[1]), .rx_busy(busy_w[1]));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_c (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_in(rx_line[2]), .rx_out(out_c),
    .rx_valid(val_w[2]), .rx_frame_err(fe_w[2]), .rx_parity_err(pe_w[2]), .rx_busy(busy_w[2]));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(5)) u_d (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_in(rx_line[3]), .rx_out(out_d),
    .rx_valid(val_w[3]), .rx_frame_err(fe_w[3]), .rx_parity_err(pe_w[3]), .rx_busy(busy_w[3]));

  assign out_w[0] = {1'b0, out_a};
  assign out_w[1] = {1'b0, out_b};
  assign out_w[2] = {1'b0, out_c};
  assign out_w[3] = {4'd0, out_d};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  task automatic qpush(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  // Output monitor: every strobe must match the oldest expected frame.
  always @(negedge rx_clk) begin
    for (int k = 0; k < 4; k++) begin
      if (val_w[k]) begin
        if (qsize(k) == 0) begin
          chk($sformatf("u%0d_unexpected_valid", k), {31'd0, val_w[k]}, 32'd0);
        end else begin
          exp_t e;
          e = qpop(k);
          chk($sformatf("u%0d_data", k), {23'd0, out_w[k]}, {23'd0, e.data});
          chk($sformatf("u%0d_frame_err", k), {31'd0, fe_w[k]}, {31'd0, e.fe});
          chk($sformatf("u%0d_parity_err", k), {31'd0, pe_w[k]}, {31'd0, e.pe});
        end
      end else if (fe_w[k] || pe_w[k]) begin
        chk($sformatf("u%0d_unqualified_err", k), {30'd0, fe_w[k], pe_w[k]}, 32'd0);
      end
    end
  end

  task automatic drive_bit(input int k, input logic b);
    rx_line[k] = b;
    repeat (CPB) @(negedge rx_clk);
  endtask

  // Sends one frame on line k; expectation is modelled from the bits actually sent.
  task automatic send(input int k, input logic [8:0] data, input int nd, input bit par_en,
                      input bit par_bit, input int nstop, input bit stop2, input bit push);
    exp_t e;
    logic ones;
    ones = 1'b0;
    for (int i = 0; i < nd; i++) ones = ones ^ data[i];
    e.data = data;
    e.fe   = (nstop == 2) && !stop2;
    e.pe   = par_en && ((ones ^ par_bit) != 1'b0);
    if (push) qpush(k, e);
    drive_bit(k, 1'b0);
    for (int i = 0; i < nd; i++) drive_bit(k, data[i]);
    if (par_en) drive_bit(k, par_bit);
    drive_bit(k, 1'b1);
    if (nstop == 2) drive_bit(k, stop2);
    rx_line[k] = 1'b1;
  endtask

  initial begin
    int cyc;
    bit saw_busy;
    for (int k = 0; k < 4; k++) rx_line[k] = 1'b1;
    repeat (3) @(negedge rx_clk);
    rx_rst_n = 1'b1;
    @(negedge rx_clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("u%0d_rst_out", k), {23'd0, out_w[k]}, 32'd0);
      chk($sformatf("u%0d_rst_flags", k), {28'd0, val_w[k], fe_w[k], pe_w[k], busy_w[k]}, 32'd0);
    end

    send(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    repeat (8) @(negedge rx_clk);
    send(1, 9'h007, 8, 1'b1, 1'b1, 1, 1'b1, 1'b1);
    send(1, 9'h007, 8, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    repeat (8) @(negedge rx_clk);
    send(2, 9'h03C, 8, 1'b0, 1'b0, 2, 1'b0, 1'b1);
    repeat (2 * CPB) @(negedge rx_clk);

    // Short low glitch on an idle line must be rejected.
    saw_busy = 1'b0;
    rx_line[0] = 1'b0;
    repeat (3) @(negedge rx_clk);
    rx_line[0] = 1'b1;
    cyc = 0;
    while (cyc < 20 && (busy_w[0] || !saw_busy)) begin
      if (busy_w[0]) saw_busy = 1'b1;
      @(negedge rx_clk);
      cyc++;
    end
    chk("glitch_busy_seen", {31'd0, saw_busy}, 32'd1);
    chk("glitch_busy_within_8", {31'd0, (cyc <= 8)}, 32'd1);
    repeat (CPB) @(negedge rx_clk);

    send(3, 9'h015, 5, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    send(3, 9'h00A, 5, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    repeat (8) @(negedge rx_clk);

    // Break: line held low for well over a frame.
    qpush(0, '{data: 9'h000, fe: 1'b1, pe: 1'b0});
    rx_line[0] = 1'b0;
    repeat (12 * CPB) @(negedge rx_clk);
    chk("break_idle_not_busy", {31'd0, busy_w[0]}, 32'd0);
    rx_line[0] = 1'b1;
    repeat (2 * CPB) @(negedge rx_clk);
    send(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    repeat (8) @(negedge rx_clk);

    // Reset pulse in the middle of data bit 4 abandons the frame.
    fork
      send(0, 9'h0F0, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
      begin
        repeat (5 * CPB + 8) @(negedge rx_clk);
        rx_rst_n = 1'b0;
        @(negedge rx_clk);
        rx_rst_n = 1'b1;
      end
    join
    repeat (4) @(negedge rx_clk);
    chk("rst_mid_out", {23'd0, out_w[0]}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy_w[0]}, 32'd0);
    send(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);

    cyc = 0;
    while (cyc < 200 && (q0.size() + q1.size() + q2.size() + q3.size()) != 0) begin
      @(negedge rx_clk);
      cyc++;
    end
    for (int k = 0; k < 4; k++) chk($sformatf("u%0d_missing_frames", k), qsize(k), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
